// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-224/256 compression engine: IVs, round
// constants, round count and FSM state encoding.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  // Packed {H,G,F,E,D,C,B,A}, word A at the LSB.
  localparam logic [255:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] SHA224_IV = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [31:0] SHA256_K [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round with a rolling 16-word message schedule:
// word 0 of the window is W_t, and the window shifts down by one word per round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [511:0] w_i,
  input  logic [5:0]   t_i,
  output logic [255:0] state_o,
  output logic [511:0] w_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w0, w1, w9, w14;
  logic [31:0] big_s0, big_s1, ch, maj, t1, t2;
  logic [31:0] small_s0, small_s1, w_new;

  assign {h, g, f, e, d, c, b, a} = state_i;

  assign w0  = w_i[31:0];
  assign w1  = w_i[63:32];
  assign w9  = w_i[319:288];
  assign w14 = w_i[479:448];

  assign big_s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  assign ch     = (e & f) ^ (~e & g);
  assign t1     = h + big_s1 + ch + SHA256_K[t_i] + w0;
  assign big_s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  assign maj    = (a & b) ^ (a & c) ^ (b & c);
  assign t2     = big_s0 + maj;

  assign state_o = {g, f, e, d + t1, c, b, a, t1 + t2};

  // W_{t+16} from the current window; it enters at the top as word 0 leaves.
  assign small_s0 = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
  assign small_s1 = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
  assign w_new    = small_s1 + w9 + small_s0 + w0;
  assign w_o      = {w_new, w_i[511:32]};

endmodule

// File: rtl/sha256_compress.sv
// Sequential SHA-224/256 compression engine: RPC chained rounds per clock,
// followed by one cycle of word-wise chaining addition.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  output logic         ready_o,
  input  logic         init_i,
  input  logic         sha224_i,
  input  logic [511:0] m_i,
  output logic [255:0] h_o,
  output logic         done_o
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_rpc_check
    $error("sha256_compress: RPC must be 1, 2, 4, 8 or 16");
  end

  localparam logic [5:0] LAST_CNT = 6'(SHA256_ROUNDS - RPC);

  logic [1:0]   state;
  logic [5:0]   cnt;
  logic [255:0] work;
  logic [511:0] msg;
  logic [255:0] chain;
  logic [255:0] sum;
  logic         accept;

  logic [255:0] st_chain [RPC+1];
  logic [511:0] w_chain  [RPC+1];

  assign ready_o = (state == ST_IDLE);
  assign accept  = start_i && ready_o;
  assign chain   = init_i ? (sha224_i ? SHA224_IV : SHA256_IV) : h_o;

  assign st_chain[0] = work;
  assign w_chain[0]  = msg;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    sha256_round u_round (
      .state_i (st_chain[j]),
      .w_i     (w_chain[j]),
      .t_i     (cnt + 6'(j)),
      .state_o (st_chain[j+1]),
      .w_o     (w_chain[j+1])
    );
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[32*i +: 32] = h_o[32*i +: 32] + work[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      h_o    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cnt   <= '0;
            state <= ST_RUN;
            if (init_i) h_o <= chain;
          end
        end
        ST_RUN: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= ST_FIN;
          end else begin
            cnt <= cnt + 6'(RPC);
          end
        end
        ST_FIN: begin
          h_o    <= sum;
          done_o <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: working and message registers are pure datapath and are always loaded before use, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      work <= chain;
      msg  <= m_i;
    end else if (state == ST_RUN) begin
      work <= st_chain[RPC];
      msg  <= w_chain[RPC];
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench: known-answer vectors, randomized chained blocks against
// an array-based SHA-256 model, RPC sweep, held-start and mid-block reset.
module tb_sha256_compress;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic [4:0]   start;
  logic         init;
  logic         sha224;
  logic [511:0] m;
  logic [4:0]   ready;
  logic [4:0]   done;
  logic [255:0] h [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    sha256_compress #(.RPC(1 << k)) dut (
      .clk_i    (clk),
      .rstn_i   (rstn),
      .start_i  (start[k]),
      .ready_o  (ready[k]),
      .init_i   (init),
      .sha224_i (sha224),
      .m_i      (m),
      .h_o      (h[k]),
      .done_o   (done[k])
    );
  end

  localparam logic [511:0] ABC_BLK = {32'h00000018, {14{32'h0}}, 32'h61626380};
  localparam logic [511:0] B448_1 = {
    32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70, 32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
    32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768, 32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
  localparam logic [511:0] B448_2 = {32'h000001c0, {15{32'h0}}};
  localparam logic [255:0] ABC_256 = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3, 32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [255:0] ABC_224 = {
    32'h0, 32'he36c9da7, 32'hbda0b3f7, 32'h2aadbce4, 32'hbda255b3, 32'h8642a477, 32'h3405d822, 32'h23097d22};
  localparam logic [255:0] D448 = {
    32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459, 32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
  localparam logic [255:0] MASK_ALL = {256{1'b1}};
  localparam logic [255:0] MASK_224 = {32'h0, {224{1'b1}}};

  typedef struct {
    logic [511:0] blk;
    logic         ini;
    logic         s224;
    logic [255:0] want;
    logic [255:0] mask;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-entry schedule, then 64 rounds on a word array.
  function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] out;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[32*i +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + SHA256_K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) out[32*i +: 32] = hin[32*i +: 32] + v[i];
    return out;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // Called #1 after an edge with the target engine ready; returns edges from accept to done.
  task automatic run_block(input int k, input logic [511:0] blk, input logic ini, input logic s224,
                           output int lat);
    m = blk; init = ini; sha224 = s224; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    m = rand_blk(); init = 1'($urandom); sha224 = 1'($urandom);
    lat = 0;
    while (!done[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lat3, ndone;
    logic [255:0] hprev, hin;

    // Vector table: known answers plus random blocks chained through the model.
    hprev = '0;
    for (int i = 0; i < NVEC; i++) begin
      case (i)
        1: vecs[i] = '{ABC_BLK, 1'b1, 1'b0, ABC_256, MASK_ALL};
        2: vecs[i] = '{ABC_BLK, 1'b1, 1'b1, ABC_224, MASK_224};
        3: vecs[i] = '{B448_1, 1'b1, 1'b0, '0, MASK_ALL};
        4: vecs[i] = '{B448_2, 1'b0, 1'b0, D448, MASK_ALL};
        default: vecs[i] = '{rand_blk(), (i == 0) ? 1'b0 : 1'($urandom), 1'($urandom), '0, MASK_ALL};
      endcase
      hin = vecs[i].ini ? (vecs[i].s224 ? SHA224_IV : SHA256_IV) : hprev;
      hprev = model(hin, vecs[i].blk);
      if (vecs[i].want == '0) vecs[i].want = hprev;
    end

    rstn = 1'b0; start = '0; init = 1'b0; sha224 = 1'b0; m = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("reset_ready[%0d]", k), 256'(ready[k]), 256'(1));
      check($sformatf("reset_done[%0d]", k), 256'(done[k]), 256'(0));
      check($sformatf("reset_h[%0d]", k), h[k], '0);
    end
    rstn = 1'b1;

    // Back-to-back table run: each block is accepted in the previous done cycle.
    lat3 = 0;
    for (int i = 0; i < NVEC; i++) begin
      run_block(0, vecs[i].blk, vecs[i].ini, vecs[i].s224, lat);
      check($sformatf("vec%0d_lat", i), 256'(lat), 256'(65));
      check($sformatf("vec%0d_h", i), h[0] & vecs[i].mask, vecs[i].want & vecs[i].mask);
      if (i == 3) lat3 = lat;
      if (i == 4) check("two_block_total", 256'(lat3 + lat), 256'(130));
    end

    for (int k = 1; k < 5; k++) begin
      run_block(k, ABC_BLK, 1'b1, 1'b0, lat);
      check($sformatf("rpc%0d_lat", 1 << k), 256'(lat), 256'(64 / (1 << k) + 1));
      check($sformatf("rpc%0d_h", 1 << k), h[k], ABC_256);
    end

    // start held high with garbage inputs while busy.
    @(posedge clk); #1;
    m = ABC_BLK; init = 1'b1; sha224 = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    check("hold_iv_loaded", h[0], SHA256_IV);
    check("hold_busy", 256'(ready[0]), 256'(0));
    ndone = 0;
    for (int c = 0; c < 100 && ndone == 0; c++) begin
      m = rand_blk(); init = 1'($urandom); sha224 = 1'($urandom);
      @(posedge clk); #1;
      if (done[0]) begin
        ndone++;
        start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    check("hold_h", h[0], ABC_256);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done[0]) ndone++;
    end
    check("hold_one_done", 256'(ndone), 256'(1));
    check("hold_ready", 256'(ready[0]), 256'(1));
    check("hold_h_stable", h[0], ABC_256);

    // Reset pulsed 30 cycles into a block.
    m = ABC_BLK; init = 1'b1; sha224 = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_h", h[0], '0);
    check("rst_ready", 256'(ready[0]), 256'(1));
    check("rst_done", 256'(done[0]), 256'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done[0]) ndone++;
    end
    check("rst_no_done", 256'(ndone), 256'(0));
    check("rst_h_idle", h[0], '0);
    run_block(0, ABC_BLK, 1'b1, 1'b0, lat);
    check("rst_after_lat", 256'(lat), 256'(65));
    check("rst_after_h", h[0], ABC_256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
